mem_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register in the 8-bit pipelined core.
- Takes the MEM_* bundle and resolves branch/jump redirection to fetch.
- Runs a req/ack handshake to a multi-cycle data memory and stalls the upstream pipeline until the access completes.
- Registers the MEM/WB bundle consumed by writeback.

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit pipelined core: data-memory req/ack handshake with
// timeout abort, upstream stall, branch/jump redirect and the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  MEM_aluout,
    input  logic [7:0]  MEM_read_data2,
    input  logic [31:0] MEM_reg_write_addr,
    input  logic [31:0] MEM_branch_addr,
    input  logic [31:0] MEM_jump_addr,
    input  logic        MEM_zr,
    input  logic        MEM_Branch,
    input  logic        MEM_BranchFlip,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Jump,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [7:0]  dmem_wdata,
    input  logic [7:0]  dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        mem_err,
    output logic [7:0]  WB_aluout,
    output logic [7:0]  WB_mem_data,
    output logic [31:0] WB_reg_write_addr,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_count;
    logic [7:0] r_rdata;
    logic       r_abort;

    logic w_mem_op;
    logic w_stall;
    logic w_branch_taken;
    logic w_in_done;

    assign w_mem_op       = MEM_MemRead | MEM_MemWrite;
    assign w_in_done      = (r_state == S_DONE);
    // Reset also releases the upstream pipeline, even if a memory op is still presented.
    assign w_stall        = !reset && ((r_state == S_IDLE && w_mem_op) || r_state == S_ACCESS);
    assign stall          = w_stall;
    assign w_branch_taken = MEM_Branch & (MEM_zr ^ MEM_BranchFlip);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pc_sel    = 1'b0;
        pc_target = '0;
        if (!w_stall) begin
            if (MEM_Jump) begin
                pc_sel    = 1'b1;
                pc_target = MEM_jump_addr;
            end else if (w_branch_taken) begin
                pc_sel    = 1'b1;
                pc_target = MEM_branch_addr;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_count           <= '0;
            r_rdata           <= '0;
            r_abort           <= 1'b0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            mem_err           <= 1'b0;
            WB_aluout         <= '0;
            WB_mem_data       <= '0;
            WB_reg_write_addr <= '0;
            WB_RegWrite       <= 1'b0;
            WB_MemtoReg       <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state    <= S_ACCESS;
                        r_count    <= '0;
                        r_rdata    <= '0;
                        r_abort    <= 1'b0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MemWrite;
                        dmem_addr  <= MEM_aluout;
                        dmem_wdata <= MEM_read_data2;
                    end
                end
                S_ACCESS: begin
                    // An ack on the final allowed cycle still completes the access.
                    if (dmem_ack) begin
                        r_rdata  <= dmem_we ? 8'h00 : dmem_rdata;
                        dmem_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_count == LP_LAST) begin
                        r_rdata  <= '0;
                        r_abort  <= 1'b1;
                        mem_err  <= 1'b1;
                        dmem_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_stall) begin
                WB_aluout         <= '0;
                WB_mem_data       <= '0;
                WB_reg_write_addr <= '0;
                WB_RegWrite       <= 1'b0;
                WB_MemtoReg       <= 1'b0;
            end else begin
                WB_aluout         <= MEM_aluout;
                WB_mem_data       <= (w_in_done && MEM_MemRead) ? r_rdata : 8'h00;
                WB_reg_write_addr <= MEM_reg_write_addr;
                WB_RegWrite       <= MEM_RegWrite & ~(w_in_done & r_abort);
                WB_MemtoReg       <= MEM_MemtoReg;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes hand-computed expectations,
// a negedge monitor pops them at each retire and checks redirect, handshake and WB.
module tb_mem_stage;

    typedef struct {
        logic [7:0]  aluout;
        logic [7:0]  rd2;
        logic [31:0] dst;
        logic [31:0] baddr;
        logic [31:0] jaddr;
        logic        zr;
        logic        branch;
        logic        flip;
        logic        mread;
        logic        mwrite;
        logic        jump;
        logic        rw;
        logic        m2r;
    } bundle_t;

    typedef struct {
        logic        pc_sel;
        logic [31:0] pc_target;
        int          stall_cyc;
        int          req_cyc;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        err;
        logic [7:0]  wb_alu;
        logic [7:0]  wb_data;
        logic [31:0] wb_dst;
        logic        wb_rw;
        logic        wb_m2r;
    } exp_t;

    logic        clk, reset;
    logic [7:0]  MEM_aluout, MEM_read_data2;
    logic [31:0] MEM_reg_write_addr, MEM_branch_addr, MEM_jump_addr;
    logic        MEM_zr, MEM_Branch, MEM_BranchFlip, MEM_MemRead, MEM_MemWrite;
    logic        MEM_Jump, MEM_RegWrite, MEM_MemtoReg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_sel, mem_err;
    logic [31:0] pc_target;
    logic [7:0]  WB_aluout, WB_mem_data;
    logic [31:0] WB_reg_write_addr;
    logic        WB_RegWrite, WB_MemtoReg;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .MEM_aluout(MEM_aluout), .MEM_read_data2(MEM_read_data2),
        .MEM_reg_write_addr(MEM_reg_write_addr), .MEM_branch_addr(MEM_branch_addr),
        .MEM_jump_addr(MEM_jump_addr), .MEM_zr(MEM_zr), .MEM_Branch(MEM_Branch),
        .MEM_BranchFlip(MEM_BranchFlip), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Jump(MEM_Jump), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .pc_sel(pc_sel),
        .pc_target(pc_target), .mem_err(mem_err), .WB_aluout(WB_aluout), .WB_mem_data(WB_mem_data),
        .WB_reg_write_addr(WB_reg_write_addr), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    int         ack_delay = 0;
    logic [7:0] rd_val    = 8'h00;
    logic       late_ack  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bundle_t b);
        MEM_aluout         = b.aluout;
        MEM_read_data2     = b.rd2;
        MEM_reg_write_addr = b.dst;
        MEM_branch_addr    = b.baddr;
        MEM_jump_addr      = b.jaddr;
        MEM_zr             = b.zr;
        MEM_Branch         = b.branch;
        MEM_BranchFlip     = b.flip;
        MEM_MemRead        = b.mread;
        MEM_MemWrite       = b.mwrite;
        MEM_Jump           = b.jump;
        MEM_RegWrite       = b.rw;
        MEM_MemtoReg       = b.m2r;
    endtask

    // Called at posedge+1: present the bundle, hold it until its retire cycle.
    task automatic issue(input bundle_t b, input int ack_d, input logic [7:0] rd,
                         input logic late, input exp_t e);
        bit retired = 0;
        ack_delay = ack_d;
        rd_val    = rd;
        late_ack  = late;
        drive(b);
        sb.push_back(e);
        for (int i = 0; i < 40 && !retired; i++) begin
            @(negedge clk);
            if (!stall) retired = 1;
        end
        if (!retired) check("retire_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Memory model: counts request cycles and acks on the programmed one.
    initial begin
        int acc_cnt = 0;
        dmem_ack   = 1'b0;
        dmem_rdata = 8'hEE;
        forever begin
            @(posedge clk);
            #2;
            if (dmem_req) begin
                acc_cnt++;
                dmem_ack   = (ack_delay != 0) && (acc_cnt == ack_delay);
                dmem_rdata = dmem_ack ? rd_val : 8'hEE;
            end else begin
                acc_cnt    = 0;
                dmem_ack   = late_ack;
                dmem_rdata = 8'hEE;
            end
        end
    end

    // Monitor: per-cycle handshake checks, retire-cycle redirect checks, WB checks one edge later.
    initial begin
        exp_t e, pe;
        bit   pend = 0;
        int   stall_cnt = 0;
        int   req_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                pend = 0;
                stall_cnt = 0;
                req_cnt = 0;
            end else begin
                if (pend) begin
                    check("wb_aluout",   32'(WB_aluout),   32'(pe.wb_alu));
                    check("wb_mem_data", 32'(WB_mem_data), 32'(pe.wb_data));
                    check("wb_dst",      WB_reg_write_addr, pe.wb_dst);
                    check("wb_regwrite", 32'(WB_RegWrite), 32'(pe.wb_rw));
                    check("wb_memtoreg", 32'(WB_MemtoReg), 32'(pe.wb_m2r));
                    pend = 0;
                end
                if (sb.size() != 0) begin
                    if (dmem_req) begin
                        req_cnt++;
                        check("req_we",    32'(dmem_we),    32'(sb[0].we));
                        check("req_addr",  32'(dmem_addr),  32'(sb[0].addr));
                        check("req_wdata", 32'(dmem_wdata), 32'(sb[0].wdata));
                    end
                    if (stall) begin
                        stall_cnt++;
                        check("pc_sel_in_stall", 32'(pc_sel), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("pc_sel",     32'(pc_sel),  32'(e.pc_sel));
                        check("pc_target",  pc_target,    e.pc_target);
                        check("stall_cyc",  stall_cnt,    e.stall_cyc);
                        check("req_cyc",    req_cnt,      e.req_cyc);
                        check("mem_err",    32'(mem_err), 32'(e.err));
                        pe = e;
                        pend = 1;
                        stall_cnt = 0;
                        req_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t bz;
        bz = '{8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
        reset = 1'b1;
        drive(bz);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",     32'(dmem_req),    32'd0);
        check("rst_stall",   32'(stall),       32'd0);
        check("rst_mem_err", 32'(mem_err),     32'd0);
        check("rst_wb_alu",  32'(WB_aluout),   32'd0);
        check("rst_wb_rw",   32'(WB_RegWrite), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Load, ack on first ACCESS cycle
        issue('{8'h3C, 8'h11, 32'd5, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 1}, 1, 8'hA5, 0,
              '{0, 32'h0, 2, 1, 0, 8'h3C, 8'h11, 0, 8'h3C, 8'hA5, 32'd5, 1, 1});
        // Store, ack on fourth ACCESS cycle
        issue('{8'h10, 8'h7E, 32'd9, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0}, 4, 8'h00, 0,
              '{0, 32'h0, 5, 4, 1, 8'h10, 8'h7E, 0, 8'h10, 8'h00, 32'd9, 0, 0});
        // BEQ taken
        issue('{8'h22, 8'h00, 32'd0, 32'h40, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0}, 0, 8'h00, 0,
              '{1, 32'h40, 0, 0, 0, 8'h00, 8'h00, 0, 8'h22, 8'h00, 32'd0, 0, 0});
        // BNE with zr=1: not taken
        issue('{8'h00, 8'h00, 32'd0, 32'h40, 32'h0, 1, 1, 1, 0, 0, 0, 0, 0}, 0, 8'h00, 0,
              '{0, 32'h0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 32'd0, 0, 0});
        // BNE with zr=0: taken
        issue('{8'h01, 8'h00, 32'd0, 32'h44, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0}, 0, 8'h00, 0,
              '{1, 32'h44, 0, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 32'd0, 0, 0});
        // Jump wins over taken branch
        issue('{8'h02, 8'h00, 32'd0, 32'h40, 32'h80, 1, 1, 0, 0, 0, 1, 0, 0}, 0, 8'h00, 0,
              '{1, 32'h80, 0, 0, 0, 8'h00, 8'h00, 0, 8'h02, 8'h00, 32'd0, 0, 0});
        // Plain ALU op
        issue('{8'h5A, 8'h00, 32'h1F, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0}, 0, 8'h00, 0,
              '{0, 32'h0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h5A, 8'h00, 32'h1F, 1, 0});
        // Flushed bubble
        issue(bz, 0, 8'h00, 0,
              '{0, 32'h0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 32'd0, 0, 0});
        // MemRead and MemWrite together behave as a write
        issue('{8'h20, 8'h33, 32'd7, 32'h0, 32'h0, 0, 0, 0, 1, 1, 0, 1, 1}, 2, 8'hCC, 0,
              '{0, 32'h0, 3, 2, 1, 8'h20, 8'h33, 0, 8'h20, 8'h00, 32'd7, 1, 1});
        // Load acked on the last allowed cycle completes normally
        issue('{8'h44, 8'h00, 32'd4, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 1}, 15, 8'h5C, 0,
              '{0, 32'h0, 16, 15, 0, 8'h44, 8'h00, 0, 8'h44, 8'h5C, 32'd4, 1, 1});
        // Load never acked: abort after 15 request cycles
        issue('{8'h77, 8'h00, 32'd3, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 1}, 0, 8'h00, 0,
              '{0, 32'h0, 16, 15, 0, 8'h77, 8'h00, 1, 8'h77, 8'h00, 32'd3, 0, 1});
        // Late ack outside ACCESS is ignored
        issue('{8'h01, 8'h00, 32'd2, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0}, 0, 8'h00, 1,
              '{0, 32'h0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 32'd2, 1, 0});
        late_ack = 1'b0;

        // Reset in the middle of an unacked access
        ack_delay = 0;
        drive('{8'h50, 8'h00, 32'd6, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 1});
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_req",     32'(dmem_req),          32'd0);
        check("mid_rst_stall",   32'(stall),             32'd0);
        check("mid_rst_wb_alu",  32'(WB_aluout),         32'd0);
        check("mid_rst_wb_data", 32'(WB_mem_data),       32'd0);
        check("mid_rst_wb_dst",  WB_reg_write_addr,      32'd0);
        check("mid_rst_wb_rw",   32'(WB_RegWrite),       32'd0);
        check("mid_rst_wb_m2r",  32'(WB_MemtoReg),       32'd0);
        drive(bz);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fresh load after reset
        issue('{8'h61, 8'h00, 32'd8, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 1}, 1, 8'h9B, 0,
              '{0, 32'h0, 2, 1, 0, 8'h61, 8'h00, 0, 8'h61, 8'h9B, 32'd8, 1, 1});

        drive(bz);
        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
